// File: rtl/bus_slave_sel.sv
// Registered bus slave selector: decodes the top address bits to a one-hot chip-select and holds it until the slave is ready.
// Optional hung-slave timeout is built in when BUS_SEL_TIMEOUT_EN is defined.
module bus_slave_sel #(
  parameter int NUM_SLAVES = 8,
  parameter int ADDR_W     = 32,
  parameter int IDX_W      = 3,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m_req,
  input  logic [ADDR_W-1:0]     m_addr,
  output logic                  m_ack,
  output logic                  m_err,
  output logic                  busy,
  output logic [NUM_SLAVES-1:0] s_cs,
  input  logic [NUM_SLAVES-1:0] s_rdy,
  output logic [IDX_W-1:0]      s_idx
);

  typedef enum logic [1:0] {IDLE, ACCESS, ERR} state_t;

  localparam logic [IDX_W:0] NS_EXT = (IDX_W+1)'(NUM_SLAVES);

  state_t                  state, state_nxt;
  logic [NUM_SLAVES-1:0]   cs_nxt;
  logic [IDX_W-1:0]        idx_in, idx_nxt;
  logic [IDX_W:0]          idx_ext;
  logic                    mapped;
  logic                    rdy_sel;
  logic                    expired;
  logic                    unused_addr;

  assign idx_in      = m_addr[ADDR_W-1 -: IDX_W];
  assign idx_ext     = {1'b0, idx_in};
  assign mapped      = idx_ext < NS_EXT;
  assign unused_addr = ^m_addr[ADDR_W-IDX_W-1:0];
  // s_cs is one-hot at s_idx during ACCESS, so masking picks exactly s_rdy[s_idx]
  assign rdy_sel     = |(s_rdy & s_cs);
  assign busy        = (state != IDLE);

`ifdef BUS_SEL_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt, cnt_nxt;

  assign expired = (state == ACCESS) && (cnt == CNT_LAST) && !rdy_sel;

  always_comb begin
    cnt_nxt = cnt;
    if (state == IDLE)
      cnt_nxt = '0;
    else if (state == ACCESS && !rdy_sel)
      cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_nxt;
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      s_cs  <= '0;
      s_idx <= '0;
    end else begin
      state <= state_nxt;
      s_cs  <= cs_nxt;
      s_idx <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cs_nxt    = '0;
    idx_nxt   = s_idx;
    m_ack     = 1'b0;
    m_err     = 1'b0;
    case (state)
      IDLE: begin
        if (m_req) begin
          idx_nxt = idx_in;
          if (mapped) begin
            state_nxt = ACCESS;
            for (int i = 0; i < NUM_SLAVES; i++)
              cs_nxt[i] = (idx_ext == (IDX_W+1)'(i));
          end else begin
            state_nxt = ERR;
          end
        end
      end
      ACCESS: begin
        if (rdy_sel) begin
          m_ack     = 1'b1;
          state_nxt = IDLE;
        end else if (expired) begin
          m_ack     = 1'b1;
          m_err     = 1'b1;
          state_nxt = IDLE;
        end else begin
          cs_nxt = s_cs;
        end
      end
      ERR: begin
        m_ack     = 1'b1;
        m_err     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_slave_sel.sv
// Scoreboard bench for bus_slave_sel: expected completions are queued by the stimulus and
// popped by a monitor on each m_ack; directed per-cycle checks cover chip-select timing.
module tb_bus_slave_sel;

  localparam int NS = 6;
  localparam int AW = 32;
  localparam int IW = 3;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          m_req;
  logic [AW-1:0] m_addr;
  logic          m_ack, m_err, busy;
  logic [NS-1:0] s_cs, s_rdy;
  logic [IW-1:0] s_idx;

  typedef struct packed {
    logic          err;
    logic [IW-1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  bus_slave_sel #(.NUM_SLAVES(NS), .ADDR_W(AW), .IDX_W(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_addr(m_addr),
    .m_ack(m_ack), .m_err(m_err), .busy(busy),
    .s_cs(s_cs), .s_rdy(s_rdy), .s_idx(s_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push(input logic err, input logic [IW-1:0] idx);
    exp_t e;
    e.err = err;
    e.idx = idx;
    exp_q.push_back(e);
  endtask

  // completion monitor + chip-select invariants
  always @(negedge clk) begin
    if (!reset) begin
      chk("cs_onehot", {31'd0, $countones(s_cs) <= 1}, 32'd1);
      chk("cs_idle_zero", {31'd0, busy || (s_cs == '0)}, 32'd1);
      if (m_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ack_err", {31'd0, m_err}, {31'd0, e.err});
          chk("ack_idx", {29'd0, s_idx}, {29'd0, e.idx});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    m_req  = 1'b0;
    m_addr = '0;
    s_rdy  = '0;
    #3;
    chk("rst_cs", {26'd0, s_cs}, 32'd0);
    chk("rst_idx", {29'd0, s_idx}, 32'd0);
    chk("rst_ack", {31'd0, m_ack}, 32'd0);
    chk("rst_err", {31'd0, m_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc();

    // 1: mapped access to idx 2, ready three cycles after first chip-select
    m_req = 1'b1; m_addr = 32'h4000_0000; push(1'b0, 3'd2);
    cyc();
    m_req = 1'b0; m_addr = 32'hFFFF_FFFF;
    smp();
    chk("t1_cs_c1", {26'd0, s_cs}, 32'h04);
    chk("t1_idx", {29'd0, s_idx}, 32'd2);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_noack_c1", {31'd0, m_ack}, 32'd0);
    cyc(); smp();
    chk("t1_cs_c2", {26'd0, s_cs}, 32'h04);
    cyc(); smp();
    chk("t1_cs_c3", {26'd0, s_cs}, 32'h04);
    chk("t1_noack_c3", {31'd0, m_ack}, 32'd0);
    cyc();
    s_rdy = 6'b000100;
    smp();
    chk("t1_cs_c4", {26'd0, s_cs}, 32'h04);
    chk("t1_ack_c4", {31'd0, m_ack}, 32'd1);
    cyc();
    s_rdy = '0;
    smp();
    chk("t1_busy_c5", {31'd0, busy}, 32'd0);
    chk("t1_cs_c5", {26'd0, s_cs}, 32'd0);

    // 2: unmapped idx 7 -> single-cycle error completion
    m_req = 1'b1; m_addr = 32'hE000_0000; push(1'b1, 3'd7);
    cyc();
    m_req = 1'b0;
    smp();
    chk("t2_cs", {26'd0, s_cs}, 32'd0);
    chk("t2_busy", {31'd0, busy}, 32'd1);
    chk("t2_ack", {31'd0, m_ack}, 32'd1);
    chk("t2_err", {31'd0, m_err}, 32'd1);
    cyc(); smp();
    chk("t2_idle", {31'd0, busy}, 32'd0);

    // 3: back-to-back with m_req held and immediate ready
    m_req = 1'b1; m_addr = 32'h0000_0000; s_rdy = '1;
    push(1'b0, 3'd0); push(1'b0, 3'd5);
    cyc();
    m_addr = 32'hA000_0000;
    smp();
    chk("t3_cs_c1", {26'd0, s_cs}, 32'h01);
    chk("t3_ack_c1", {31'd0, m_ack}, 32'd1);
    cyc(); smp();
    chk("t3_idle_c2", {31'd0, busy}, 32'd0);
    chk("t3_cs_c2", {26'd0, s_cs}, 32'd0);
    cyc();
    m_req = 1'b0;
    smp();
    chk("t3_cs_c3", {26'd0, s_cs}, 32'h20);
    chk("t3_idx_c3", {29'd0, s_idx}, 32'd5);
    chk("t3_ack_c3", {31'd0, m_ack}, 32'd1);
    cyc();
    s_rdy = '0;
    smp();
    chk("t3_idle_c4", {31'd0, busy}, 32'd0);

    // 4: ready from a non-selected slave is ignored
    m_req = 1'b1; m_addr = 32'h2000_0000; push(1'b0, 3'd1);
    cyc();
    m_req = 1'b0;
    cyc();
    s_rdy = 6'b001000;
    smp();
    chk("t4_wrong_rdy", {31'd0, m_ack}, 32'd0);
    chk("t4_cs", {26'd0, s_cs}, 32'h02);
    cyc();
    s_rdy = '0;
    smp();
    chk("t4_still_busy", {31'd0, busy}, 32'd1);
    cyc();
    s_rdy = 6'b000010;
    smp();
    chk("t4_ack", {31'd0, m_ack}, 32'd1);
    cyc();
    s_rdy = '0;
    smp();
    chk("t4_idle", {31'd0, busy}, 32'd0);

    // 5: hung slave at idx 4
    m_req = 1'b1; m_addr = 32'h8000_0000;
`ifdef BUS_SEL_TIMEOUT_EN
    push(1'b1, 3'd4);
    cyc();
    m_req = 1'b0;
    for (int i = 1; i < TO; i++) begin
      smp();
      chk("t5_no_early_ack", {31'd0, m_ack}, 32'd0);
      cyc();
    end
    smp();
    chk("t5_to_ack", {31'd0, m_ack}, 32'd1);
    chk("t5_to_err", {31'd0, m_err}, 32'd1);
    cyc(); smp();
    chk("t5_cs_clr", {26'd0, s_cs}, 32'd0);
    chk("t5_idle", {31'd0, busy}, 32'd0);
`else
    cyc();
    m_req = 1'b0;
    begin
      int busy_cnt;
      busy_cnt = 0;
      for (int i = 0; i < 1000; i++) begin
        smp();
        if (busy) busy_cnt++;
        cyc();
      end
      chk("t5_busy_1000", busy_cnt, 32'd1000);
      chk("t5_cs_held", {26'd0, s_cs}, 32'h10);
    end
    reset = 1'b1;
    #2;
    reset = 1'b0;
    cyc();
`endif

    // 6: asynchronous reset in the middle of ACCESS
    m_req = 1'b1; m_addr = 32'h6000_0000;
    cyc();
    m_req = 1'b0;
    smp();
    chk("t6_cs", {26'd0, s_cs}, 32'h08);
    cyc(); smp();
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_cs", {26'd0, s_cs}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_ack", {31'd0, m_ack}, 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    s_rdy = '1;
    smp();
    chk("t6_post_busy", {31'd0, busy}, 32'd0);
    cyc(); smp();
    chk("t6_post_noack", {31'd0, m_ack}, 32'd0);
    m_req = 1'b1; m_addr = 32'h4000_0000; push(1'b0, 3'd2);
    cyc();
    m_req = 1'b0;
    smp();
    chk("t6_new_cs", {26'd0, s_cs}, 32'h04);
    chk("t6_new_ack", {31'd0, m_ack}, 32'd1);
    cyc();
    s_rdy = '0;
    smp();
    chk("t6_new_idle", {31'd0, busy}, 32'd0);

    cyc(); cyc();
    chk("pending_acks", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_slave_sel.md
Name: bus_slave_sel

Overview:
- Parametrised, registered successor to the combinational bus address decoder.
- Accepts one master request at a time and decodes the top IDX_W address bits to a one-hot slave chip-select.
- Holds the chip-select until the selected slave signals ready, and returns a completion acknowledge to the master.
- Unmapped addresses and optionally hung slaves get an error completion, so the bus never deadlocks.
- Sits between the bus arbiter output and the slave read-data mux; s_idx drives the mux select.

Parameters:
- NUM_SLAVES, 8, number of attached slaves; legal range 1 to 2^IDX_W.
- ADDR_W, 32, master address width.
- IDX_W, 3, number of top address bits used as slave index; index = m_addr[ADDR_W-1 -: IDX_W].
- TIMEOUT, 256, cycles allowed in ACCESS before error completion; only used with BUS_SEL_TIMEOUT_EN; minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m_req  in  1  master request; sampled only in IDLE.
- m_addr  in  ADDR_W  master address; sampled with m_req.
- m_ack  out  1  one-cycle completion pulse.
- m_err  out  1  error flag; valid only while m_ack=1.
- busy  out  1  high whenever state != IDLE.
- s_cs  out  NUM_SLAVES  one-hot slave chip-selects, registered.
- s_rdy  in  NUM_SLAVES  per-slave ready/done.
- s_idx  out  IDX_W  latched slave index for the read-data mux.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, s_cs=0, s_idx=0, m_ack=0, m_err=0, busy=0, timeout counter=0. Reset mid-transaction aborts it; no ack is issued.
- States: IDLE, ACCESS, ERR.
- IDLE:
  - If m_req=1, latch idx=m_addr[ADDR_W-1 -: IDX_W] into s_idx.
  - If idx < NUM_SLAVES: go to ACCESS; s_cs[idx]=1 from the next cycle (1-cycle latency from accept to chip-select).
  - Otherwise (unmapped): go to ERR; s_cs stays 0.
  - If m_req=0: remain in IDLE, all outputs 0.
- ACCESS:
  - s_cs holds exactly one bit set, busy=1, s_idx stable.
  - Only s_rdy[s_idx] is observed; other s_rdy bits are ignored.
  - m_ack = s_rdy[s_idx] combinationally in ACCESS; m_err=0.
  - On s_rdy[s_idx]=1: next state IDLE; s_cs clears the following cycle.
- ERR: one cycle only; m_ack=1, m_err=1; next state IDLE.
- Request acceptance:
  - m_req is ignored outside IDLE and is not queued.
  - A request asserted in the same cycle as m_ack is not accepted. The master must keep m_req high, and it is accepted in the following IDLE cycle.
  - Minimum spacing from one accept to the next is 2 cycles for an ERR completion, and 2 cycles for a slave that is ready at the first chip-select cycle.
- s_rdy already high at the first chip-select cycle: completion in that same cycle; accept at cycle 0, ack at cycle 1.
- m_addr changes after accept have no effect.
- s_cs is never multi-hot, and is never nonzero outside ACCESS.

Optional Feature:
- Macro: BUS_SEL_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT) clears on entry to ACCESS and increments each ACCESS cycle without s_rdy[s_idx].
  - When the counter reaches TIMEOUT-1 with s_rdy[s_idx]=0, that cycle outputs m_ack=1, m_err=1, and the next state is IDLE (s_cs clears the next cycle).
  - If s_rdy[s_idx] is high in the expiry cycle, it is a normal completion with m_err=0.
- Not defined: no counter is present, and ACCESS waits indefinitely for s_rdy.

Test Plan:
1. Mapped access: m_addr=0x4000_0000 (idx 2), s_rdy[2] high 3 cycles after cs -> s_cs=8'b0000_0100 from cycle 1 to cycle 4, s_idx=2, m_ack=1 with m_err=0 at cycle 4, busy low at cycle 5.
2. Unmapped access: NUM_SLAVES=6, m_addr=0xE000_0000 (idx 7) -> s_cs stays 0, m_ack=1 and m_err=1 at cycle 1, IDLE at cycle 2.
3. Back-to-back: m_req held high, addresses idx 0 then idx 5, immediate s_rdy -> s_cs=0x01 at cycle 1, ack at cycle 1, second accept at cycle 2, s_cs=0x20 at cycle 3; s_cs is never multi-hot.
4. Wrong-slave ready: idx 1 selected, s_rdy[3] pulsed -> no ack; ack only when s_rdy[1]=1.
5. Timeout (macro on, TIMEOUT=16): idx 4 selected, s_rdy held 0 -> m_ack=1 and m_err=1 on the 16th ACCESS cycle, s_cs=0 the next cycle. With the macro off, busy stays 1 for at least 1000 cycles.
6. Reset mid-ACCESS: assert reset asynchronously between clock edges -> s_cs, busy, and m_ack go to 0 immediately; no ack after release; a new request is accepted normally.
